or_8bit: RTL and testbench
==========================

OR_8BIT -- requirements
Module: or_8bit

Interface
REQ-001 Parameter WIDTH, default 8, data width of inA, inB, out, outQ and stickyQ; the required build is WIDTH=8.
REQ-002 Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all registered outputs.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 inA  input  WIDTH  operand A.
REQ-006 inB  input  WIDTH  operand B.
REQ-007 en  input  1  register-update enable for outQ, anyQ and stickyQ.
REQ-008 clr  input  1  synchronous clear of stickyQ.
REQ-009 out  output  WIDTH  combinational bitwise OR of inA and inB.
REQ-010 outQ  output  WIDTH  registered copy of out.
REQ-011 anyQ  output  1  registered reduction-OR of out.
REQ-012 stickyQ  output  WIDTH  registered accumulated OR (see Configuration).

Function
REQ-013 out SHALL equal inA | inB bit-for-bit at all times, purely combinational, with no dependence on clk, rst_n, en or clr.
REQ-014 out SHALL settle within the same simulation time step as an input change; a check 1 time unit after the change must see the final value.
REQ-015 out SHALL propagate X/Z per standard OR semantics: a 1 on either operand forces that bit to 1.
REQ-016 On each rising clk edge with rst_n=1 and en=1: outQ <= inA|inB, and anyQ <= |(inA|inB).
REQ-017 With en=0, outQ and anyQ SHALL hold their values.
REQ-018 Latency of outQ and anyQ relative to the inputs SHALL be exactly 1 clock.
REQ-019 No handshake; every enabled cycle is a valid sample.
REQ-020 Simultaneous clr=1 and en=1 (sticky build): clr wins and stickyQ <= 0, with no OR-in that cycle.

Reset
REQ-021 rst_n=0 SHALL immediately, without a clock, force outQ=0, anyQ=0 and stickyQ=0.
REQ-022 out SHALL remain inA|inB during reset.
REQ-023 Reset deassertion: registers SHALL update starting from the first rising edge after rst_n=1.
REQ-024 Reset asserted mid-operation SHALL discard accumulated state.

Configuration
REQ-025 Macro OR_8BIT_STICKY_EN SHALL control the sticky accumulator.
REQ-026 When OR_8BIT_STICKY_EN is defined, at each rising edge: if clr=1, stickyQ <= 0; else if en=1, stickyQ <= stickyQ | inA | inB; else stickyQ holds.
REQ-027 When OR_8BIT_STICKY_EN is undefined, stickyQ SHALL be tied to 0 and clr SHALL be ignored.

Verification
REQ-028 Combinational truth vectors, each checked 1 time unit after the inputs are applied:
- 00|00 -> 00
- 00|FF -> FF
- FF|FF -> FF
- AA|55 -> FF
- C3|F0 -> F3
- 34|76 -> 76
REQ-029 Reset: rst_n=0 mid-stream with outQ=FF -> outQ=00 and anyQ=0 before the next clk edge; out unchanged.
REQ-030 Enable: en=1, inA=C3, inB=F0 -> outQ=F3, anyQ=1 one clock later; then en=0 with inputs 00/00 -> outQ stays F3.
REQ-031 Zero reduction: en=1, inA=00, inB=00 -> anyQ=0 after one clock.
REQ-032 Sticky (macro defined): apply 01|02, then 10|00, then 00|80, each with en=1 -> stickyQ=93; then clr=1 with en=1 -> stickyQ=00.
REQ-033 Sticky (macro undefined): the same sequence -> stickyQ=00 throughout.

Source files
------------

// File: rtl/or_8bit.sv
// Bitwise OR of two operands with registered copy, registered any-bit flag and an
// optional sticky accumulator enabled by defining OR_8BIT_STICKY_EN.
module or_8bit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] outQ,
   output logic             anyQ,
   output logic [WIDTH-1:0] stickyQ
);

   // Continuous OR keeps X/Z semantics: a 1 on either side forces the bit high.
   assign out = inA | inB;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outQ <= '0;
         anyQ <= 1'b0;
      end else if (en) begin
         outQ <= out;
         anyQ <= |out;
      end
   end

`ifdef OR_8BIT_STICKY_EN
   // Clear has priority over accumulation when both are asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stickyQ <= '0;
      end else if (clr) begin
         stickyQ <= '0;
      end else if (en) begin
         stickyQ <= stickyQ | out;
      end
   end
`else
   logic unused_clr;

   assign stickyQ    = '0;
   assign unused_clr = clr;
`endif

endmodule

// File: tb/tb_or_8bit.sv
// Self-checking bench for or_8bit: combinational truth table, enable/latency,
// async reset and the sticky accumulator (expectations follow OR_8BIT_STICKY_EN).
module tb_or_8bit;

   localparam int WIDTH = 8;
`ifdef OR_8BIT_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   typedef struct {
      string            name;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] exp;
   } comb_vec_t;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] inA;
   logic [WIDTH-1:0] inB;
   logic             en;
   logic             clr;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] outQ;
   logic             anyQ;
   logic [WIDTH-1:0] stickyQ;

   int n_checks = 0;
   int n_fail   = 0;

   or_8bit #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .inA     (inA),
      .inB     (inB),
      .en      (en),
      .clr     (clr),
      .out     (out),
      .outQ    (outQ),
      .anyQ    (anyQ),
      .stickyQ (stickyQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Returns 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   comb_vec_t vecs[8];
   logic [WIDTH-1:0] sticky_exp;

   initial begin
      vecs[0] = '{"or_00_00", 8'h00, 8'h00, 8'h00};
      vecs[1] = '{"or_00_ff", 8'h00, 8'hFF, 8'hFF};
      vecs[2] = '{"or_ff_ff", 8'hFF, 8'hFF, 8'hFF};
      vecs[3] = '{"or_aa_55", 8'hAA, 8'h55, 8'hFF};
      vecs[4] = '{"or_c3_f0", 8'hC3, 8'hF0, 8'hF3};
      vecs[5] = '{"or_34_76", 8'h34, 8'h76, 8'h76};
      vecs[6] = '{"or_x_one", 8'b1111_xxxx, 8'h0F, 8'hFF};
      vecs[7] = '{"or_x_zero", 8'b xxxx_0000, 8'h00, 8'b xxxx_0000};

      rst_n = 1'b0;
      en    = 1'b0;
      clr   = 1'b0;
      inA   = 8'h00;
      inB   = 8'h00;
      #2;
      check("reset_outQ", outQ, 8'h00);
      check("reset_anyQ", {7'd0, anyQ}, 8'h00);
      check("reset_stickyQ", stickyQ, 8'h00);
      inA = 8'h12;
      inB = 8'h40;
      #1;
      check("out_during_reset", out, 8'h52);

      // Release between edges so the next rising edge is the first active one.
      #5;
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         inA = vecs[i].a;
         inB = vecs[i].b;
         #1;
         check(vecs[i].name, out, vecs[i].exp);
      end

      // Enable and one-clock latency.
      tick();
      check("en0_outQ_holds_reset", outQ, 8'h00);
      en  = 1'b1;
      inA = 8'hC3;
      inB = 8'hF0;
      #1;
      check("latency_outQ_before_edge", outQ, 8'h00);
      tick();
      check("en_outQ", outQ, 8'hF3);
      check("en_anyQ", {7'd0, anyQ}, 8'h01);
      en  = 1'b0;
      inA = 8'h00;
      inB = 8'h00;
      tick();
      tick();
      check("hold_outQ", outQ, 8'hF3);
      check("hold_anyQ", {7'd0, anyQ}, 8'h01);

      // Zero reduction.
      en = 1'b1;
      tick();
      check("zero_anyQ", {7'd0, anyQ}, 8'h00);
      check("zero_outQ", outQ, 8'h00);

      // Sticky accumulation, then clear winning over enable.
      inA = 8'h01; inB = 8'h02;
      tick();
      check("sticky_step1", stickyQ, STICKY ? 8'h03 : 8'h00);
      inA = 8'h10; inB = 8'h00;
      tick();
      check("sticky_step2", stickyQ, STICKY ? 8'h13 : 8'h00);
      inA = 8'h00; inB = 8'h80;
      tick();
      check("sticky_step3", stickyQ, STICKY ? 8'h93 : 8'h00);
      check("sticky_step3_outQ", outQ, 8'h80);
      en  = 1'b0;
      inA = 8'h0C; inB = 8'h00;
      tick();
      check("sticky_hold_en0", stickyQ, STICKY ? 8'h93 : 8'h00);
      en  = 1'b1;
      clr = 1'b1;
      tick();
      check("sticky_clr_wins", stickyQ, 8'h00);
      check("clr_outQ_still_updates", outQ, 8'h0C);
      clr = 1'b0;
      inA = 8'h05; inB = 8'h20;
      tick();
      sticky_exp = STICKY ? 8'h25 : 8'h00;
      check("sticky_after_clr", stickyQ, sticky_exp);

      // Mid-stream async reset discards all state without a clock.
      inA = 8'hFF; inB = 8'h00;
      tick();
      check("pre_reset_outQ", outQ, 8'hFF);
      rst_n = 1'b0;
      #1;
      check("async_reset_outQ", outQ, 8'h00);
      check("async_reset_anyQ", {7'd0, anyQ}, 8'h00);
      check("async_reset_stickyQ", stickyQ, 8'h00);
      check("async_reset_out", out, 8'hFF);
      #1;
      rst_n = 1'b1;
      #1;
      check("post_release_no_update", outQ, 8'h00);
      tick();
      check("first_edge_after_release", outQ, 8'hFF);
      check("first_edge_anyQ", {7'd0, anyQ}, 8'h01);
      check("first_edge_stickyQ", stickyQ, STICKY ? 8'hFF : 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
